uart_rx: RTL

Serial receiver paired with `uart_tx` on the CORDIC-UART link.
- Samples the asynchronous `i_rx` line and deframes start/data/parity/stop bits.
- Presents each received word as a one-cycle valid pulse to the downstream command parser.
- Frame parameters match `uart_tx`, so a loopback of the two is bit-exact.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the CORDIC-UART link (uart_tx / uart_rx).
// The parity selectors and the bit-period helper live here so both ends always agree.
package uart_pkg;

    localparam bit EVEN_PAR = 1'b0;
    localparam bit ODD_PAR  = 1'b1;

    // Clock cycles per bit, rounded to the nearest integer in integer-only arithmetic.
    function automatic int baud_cnt_max(input int clk, input int baud);
        return (clk + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter, so an idle-high line does not fake an edge when reset is released.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], i_d};
        end
    end

    assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling deframer with parity and stop-bit checking.
// Each received word is presented as a one-cycle valid pulse, with its error flags attached.
module uart_rx #(
    parameter int CLK_FREQ_MHZ  = 100_000_000,
    parameter int BAUD_RATE     = 3_000_000,
    parameter int NUM_DATA_BITS = 8,
    parameter int PARITY_ON     = 1,
    parameter int PARITY_EO     = 1,
    parameter int NUM_STOP_BITS = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rx,
    output logic                     o_rx_byte_valid,
    output logic [NUM_DATA_BITS-1:0] o_rx_byte,
    output logic                     o_parity_err,
    output logic                     o_frame_err
);
    import uart_pkg::*;

    localparam int MAX  = baud_cnt_max(CLK_FREQ_MHZ, BAUD_RATE);
    localparam int HALF = MAX / 2;
    localparam int CW   = $clog2(MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [3:0]    DATA_LAST = 4'(NUM_DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(NUM_STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [3:0]               bit_q, bit_d;
    logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
    logic                     perr_q, perr_d;
    logic                     ferr_q, ferr_d;
    logic                     valid_q, valid_d;
    logic [NUM_DATA_BITS-1:0] byte_q, byte_d;
    logic                     perr_out_q, perr_out_d;
    logic                     ferr_out_q, ferr_out_d;
    logic                     rx_s;
    logic                     parity_exp;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    assign parity_exp = (PARITY_EO == int'(ODD_PAR)) ? ~^shift_q : ^shift_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            valid_q    <= 1'b0;
            byte_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            valid_q    <= valid_d;
            byte_q     <= byte_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        valid_d    = 1'b0;
        byte_d     = byte_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            // A start bit that is high again at its midpoint is treated as a glitch.
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[NUM_DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_ON != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = (rx_s != parity_exp);
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // The word is delivered at mid-stop so that an early next start edge is not missed.
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~rx_s;
                    if (bit_q == STOP_LAST) begin
                        bit_d      = '0;
                        valid_d    = 1'b1;
                        byte_d     = shift_q;
                        perr_out_d = perr_q;
                        ferr_out_d = ferr_q | ~rx_s;
                        state_d    = rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                cnt_d      = '0;
                bit_d      = '0;
                shift_d    = '0;
                perr_d     = 1'b0;
                ferr_d     = 1'b0;
                byte_d     = '0;
                perr_out_d = 1'b0;
                ferr_out_d = 1'b0;
            end
        endcase
    end

    assign o_rx_byte_valid = valid_q;
    assign o_rx_byte       = byte_q;
    assign o_parity_err    = perr_out_q;
    assign o_frame_err     = ferr_out_q;

endmodule
